// File: rtl/histogram_equalizer_lut_pkg.sv
// Shared widths, FSM state type and CDF scaling helper for the histogram equaliser LUT builder.
package hist_eq_pkg;

    localparam int BINS   = 256;
    localparam int PIX_W  = 8;
    localparam int BIN_W  = 16;
    localparam int CDF_W  = 24;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    // Address tag travelling alongside an outstanding histogram read.
    typedef struct packed {
        logic             valid;
        logic [PIX_W-1:0] addr;
    } rd_tag_t;

    // (cdf * 255) >> shift, clamped to 255 so a full frame never wraps to 0.
    function automatic logic [PIX_W-1:0] scale_cdf(input logic [CDF_W-1:0] cdf, input int shift);
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] scaled;
        prod   = PROD_W'(cdf) * PROD_W'(255);
        scaled = prod >> shift;
        return (scaled > PROD_W'(255)) ? 8'hFF : scaled[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/histogram_equalizer_lut_if.sv
// Histogram calculator readback bus: ready pulse plus address/strobe/data read port.
interface histogram_equalizer_lut_if;
    import hist_eq_pkg::*;

    logic             hist_ready;
    logic             hist_rd_en;
    logic [PIX_W-1:0] hist_rd_addr;
    logic [BIN_W-1:0] hist_rd_data;

    // The equaliser drives the read address; the calculator returns counts.
    modport master (
        input  hist_ready,
        input  hist_rd_data,
        output hist_rd_en,
        output hist_rd_addr
    );

    modport slave (
        output hist_ready,
        output hist_rd_data,
        input  hist_rd_en,
        input  hist_rd_addr
    );

endinterface

// File: rtl/histogram_equalizer_lut_dp_bram.sv
// Simple dual-port block RAM: port a synchronous write, port b registered read.
module dp_bram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we_a,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [WIDTH-1:0]         din_a,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    output logic [WIDTH-1:0]         dout_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: RAM contents and its read register have no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/histogram_equalizer_lut.sv
// Builds an 8-bit equalisation LUT from the frame histogram and remaps the live pixel stream.
// Optional macro LUT_DOUBLE_BUF_EN selects double-buffered LUT banks swapped at frame end.
module histogram_equalizer_lut
    import hist_eq_pkg::*;
#(
    parameter int LOG2_PIXELS = 16,
    parameter int RD_LATENCY  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PIX_W-1:0]           in_pixel,
    input  logic                       in_valid,
    input  logic                       end_of_frame,
    histogram_equalizer_lut_if.master  hist,
    output logic [PIX_W-1:0]           out_pixel,
    output logic                       out_valid,
    output logic                       out_end_of_frame,
    output logic                       busy,
    output logic                       lut_valid,
    output logic                       overrun
);

    state_t           state;
    state_t           next_state;
    logic [PIX_W-1:0] rd_addr;
    rd_tag_t          rd_pipe [RD_LATENCY];
    logic [CDF_W-1:0] cdf;
    logic             wr_en;
    logic [PIX_W-1:0] wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic             build_start;
    logic             last_write;

    logic [PIX_W-1:0] pix_q;
    logic [PIX_W-1:0] pix_qq;
    logic             valid_q;
    logic             eof_q;
    logic             use_lut_q;
    logic [PIX_W-1:0] lut_dout;

    assign build_start       = (state == IDLE) && hist.hist_ready;
    assign last_write        = wr_en && (wr_addr == PIX_W'(BINS - 1));
    assign busy              = (state != IDLE);
    assign hist.hist_rd_en   = (state == READ);
    assign hist.hist_rd_addr = rd_addr;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (hist.hist_ready) next_state = READ;
            READ:    if (rd_addr == PIX_W'(BINS - 1)) next_state = DRAIN;
            DRAIN:   if (last_write) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr <= '0;
        end else if (build_start) begin
            rd_addr <= '0;
        end else if (state == READ) begin
            rd_addr <= rd_addr + 1'b1;
        end
    end

    // Tag each issued address so the returning count can be matched to its bin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= '{valid: (state == READ), addr: rd_addr};
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdf     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_en   <= rd_pipe[RD_LATENCY-1].valid;
            wr_addr <= rd_pipe[RD_LATENCY-1].addr;
            if (build_start) begin
                cdf <= '0;
            end else if (rd_pipe[RD_LATENCY-1].valid) begin
                cdf <= cdf + CDF_W'(hist.hist_rd_data);
            end
        end
    end

    assign wr_data = scale_cdf(cdf, LOG2_PIXELS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (busy && hist.hist_ready) begin
            overrun <= 1'b1;
        end
    end

    // Stage 1 registers the input; stage 2 is the LUT read, with a bypass copy alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q            <= '0;
            valid_q          <= 1'b0;
            eof_q            <= 1'b0;
            pix_qq           <= '0;
            out_valid        <= 1'b0;
            out_end_of_frame <= 1'b0;
            use_lut_q        <= 1'b0;
        end else begin
            pix_q            <= in_pixel;
            valid_q          <= in_valid;
            eof_q            <= in_valid && end_of_frame;
            pix_qq           <= pix_q;
            out_valid        <= valid_q;
            out_end_of_frame <= eof_q;
            use_lut_q        <= lut_valid;
        end
    end

    assign out_pixel = use_lut_q ? lut_dout : pix_qq;

`ifdef LUT_DOUBLE_BUF_EN
    logic             active_bank;
    logic             bank_q;
    logic             swap_pending;
    logic             swap;
    logic [PIX_W-1:0] dout0;
    logic [PIX_W-1:0] dout1;

    // Flip after the end-of-frame pixel's lookup; held off while a build rewrites the shadow bank.
    assign swap = swap_pending && !busy && valid_q && eof_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_bank  <= 1'b0;
            bank_q       <= 1'b0;
            swap_pending <= 1'b0;
            lut_valid    <= 1'b0;
        end else begin
            bank_q <= active_bank;
            if (last_write) begin
                swap_pending <= 1'b1;
            end else if (swap) begin
                swap_pending <= 1'b0;
                active_bank  <= ~active_bank;
                lut_valid    <= 1'b1;
            end
        end
    end

    dp_bram #(.DEPTH(BINS), .WIDTH(PIX_W)) u_bank0 (
        .clk    (clk),
        .we_a   (wr_en && active_bank),
        .addr_a (wr_addr),
        .din_a  (wr_data),
        .addr_b (pix_q),
        .dout_b (dout0)
    );

    dp_bram #(.DEPTH(BINS), .WIDTH(PIX_W)) u_bank1 (
        .clk    (clk),
        .we_a   (wr_en && !active_bank),
        .addr_a (wr_addr),
        .din_a  (wr_data),
        .addr_b (pix_q),
        .dout_b (dout1)
    );

    assign lut_dout = bank_q ? dout1 : dout0;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut_valid <= 1'b0;
        end else if (build_start) begin
            lut_valid <= 1'b0;
        end else if (last_write) begin
            lut_valid <= 1'b1;
        end
    end

    dp_bram #(.DEPTH(BINS), .WIDTH(PIX_W)) u_bank0 (
        .clk    (clk),
        .we_a   (wr_en),
        .addr_a (wr_addr),
        .din_a  (wr_data),
        .addr_b (pix_q),
        .dout_b (lut_dout)
    );
`endif

endmodule

// File: tb/tb_histogram_equalizer_lut.sv
// Scoreboard bench for histogram_equalizer_lut: builds tables from modelled histograms and sweeps pixels.
module tb_histogram_equalizer_lut;
    import hist_eq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_pixel;
    logic       in_valid;
    logic       end_of_frame;
    logic [7:0] out_pixel;
    logic       out_valid;
    logic       out_end_of_frame;
    logic       busy;
    logic       lut_valid;
    logic       overrun;

    histogram_equalizer_lut_if hist_bus ();

    histogram_equalizer_lut #(
        .LOG2_PIXELS (16),
        .RD_LATENCY  (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_pixel         (in_pixel),
        .in_valid         (in_valid),
        .end_of_frame     (end_of_frame),
        .hist             (hist_bus),
        .out_pixel        (out_pixel),
        .out_valid        (out_valid),
        .out_end_of_frame (out_end_of_frame),
        .busy             (busy),
        .lut_valid        (lut_valid),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    // Histogram RAM model with one cycle of read latency.
    logic [15:0] hist_mem [256];
    always @(posedge clk) hist_bus.hist_rd_data <= hist_mem[hist_bus.hist_rd_addr];

    typedef struct {
        logic [7:0] pix;
        logic       eof;
        int         cyc;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] cur_lut [256];
    logic [7:0] new_lut [256];
    logic       cur_valid;
    int         vectors = 0;
    int         miscompares = 0;
    int         busy_cycles = 0;
    int         cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        busy_cycles += int'(busy);
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", out_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_pixel", out_pixel, e.pix);
                check("out_eof", out_end_of_frame, e.eof);
                check("latency", cyc - e.cyc, 2);
            end
        end
    end

    // Reference table straight from the definition: min(255, cdf*255 / 2^16).
    function automatic void build_model();
        longint cdf_m = 0;
        longint v;
        for (int i = 0; i < 256; i++) begin
            cdf_m += hist_mem[i];
            v = (cdf_m * 255) >> 16;
            new_lut[i] = (v > 255) ? 8'hFF : 8'(v);
        end
    endfunction

    task automatic send_pixel(input logic [7:0] p, input logic eof);
        exp_t e;
        e.pix = cur_valid ? cur_lut[p] : p;
        e.eof = eof;
        e.cyc = cyc;
        in_pixel = p;
        in_valid = 1'b1;
        end_of_frame = eof;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        end_of_frame = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sweep();
        for (int i = 0; i < 256; i++) begin
            send_pixel(8'(i), i == 255);
        end
        idle(4);
    endtask

    // Pulse hist_ready, stream pixels during the build, optionally re-pulse at overrun_at.
    task automatic run_build(input int overrun_at);
        build_model();
        busy_cycles = 0;
        hist_bus.hist_ready = 1'b1;
        @(negedge clk);
        hist_bus.hist_ready = 1'b0;
`ifndef LUT_DOUBLE_BUF_EN
        cur_valid = 1'b0;
`endif
        for (int i = 0; i < 40; i++) begin
            if (i == overrun_at) hist_bus.hist_ready = 1'b1;
            send_pixel(8'(i * 7), i == 39);
            hist_bus.hist_ready = 1'b0;
        end
        for (int k = 0; k < 2000; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_timeout", busy, 1'b0);
        check("busy_cycles", busy_cycles, 258);
`ifdef LUT_DOUBLE_BUF_EN
        send_pixel(8'h11, 1'b1);
`else
        check("lut_valid_built", lut_valid, 1'b1);
`endif
        for (int i = 0; i < 256; i++) cur_lut[i] = new_lut[i];
        cur_valid = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_pixel = '0;
        in_valid = 1'b0;
        end_of_frame = 1'b0;
        hist_bus.hist_ready = 1'b0;
        cur_valid = 1'b0;
        for (int i = 0; i < 256; i++) hist_mem[i] = '0;
        idle(3);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pixel", out_pixel, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_lut_valid", lut_valid, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_rd_en", hist_bus.hist_rd_en, 1'b0);
        rst = 1'b0;
        idle(2);

        // Bypass before any table exists.
        send_pixel(8'h5A, 1'b0);
        send_pixel(8'hC3, 1'b1);
        idle(4);
        check("prebuild_lut_valid", lut_valid, 1'b0);

        // Uniform histogram: identity-like ramp.
        for (int i = 0; i < 256; i++) hist_mem[i] = 16'd256;
        run_build(-1);
        sweep();
        check("uniform_lut_valid", lut_valid, 1'b1);

        // Whole frame in bin 0: saturation without wrap.
        for (int i = 0; i < 256; i++) hist_mem[i] = '0;
        hist_mem[0] = 16'hFFFF;
        hist_mem[1] = 16'd1;
        run_build(-1);
        sweep();

        // Second hist_ready mid-build is ignored but flagged.
        for (int i = 0; i < 256; i++) hist_mem[i] = 16'((i * 37) % 300 + 1);
        check("overrun_before", overrun, 1'b0);
        run_build(10);
        check("overrun_set", overrun, 1'b1);
        sweep();
        check("overrun_sticky", overrun, 1'b1);

        // Reset in the middle of a build, then a clean rebuild.
        for (int i = 0; i < 256; i++) hist_mem[i] = 16'((i * 13) % 200);
        hist_bus.hist_ready = 1'b1;
        @(negedge clk);
        hist_bus.hist_ready = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (busy && hist_bus.hist_rd_addr == 8'd100) break;
            @(negedge clk);
        end
        check("abort_addr", hist_bus.hist_rd_addr, 8'd100);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_lut_valid", lut_valid, 1'b0);
        check("abort_rd_en", hist_bus.hist_rd_en, 1'b0);
        check("abort_overrun", overrun, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cur_valid = 1'b0;
        idle(2);
        send_pixel(8'h5A, 1'b0);
        idle(3);
        run_build(-1);
        sweep();

        idle(5);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
